// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequencer and the offset stage:
// FSM state encoding, step-mode codes and the default coordinate width.
package pattern_pkg;

  // Coordinate width used by the offset stage
  localparam int CW_DEFAULT = 12;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // X step-mode codes
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FOUR  = 2'b10;
  localparam logic [1:0] EIGHT = 2'b11;

endpackage

// File: rtl/pattern_step_dec.sv
// Step-mode decoder: maps the 2-bit X step mode onto the pixel delta.
// The offset stage instantiates this same decoder so both sides agree.
module pattern_step_dec
  import pattern_pkg::*;
(
  input  logic [1:0] i_mode,
  output logic [3:0] o_delta
);

  // Pure lookup of the X increment for each step mode
  always_comb begin
    o_delta = 4'd0;
    case (i_mode)
      ZERO:    o_delta = 4'd0;
      ONE:     o_delta = 4'd1;
      FOUR:    o_delta = 4'd4;
      EIGHT:   o_delta = 4'd8;
      default: o_delta = 4'd0;
    endcase
  end

endmodule

// File: rtl/pattern_line_seq.sv
// Raster sequencer: takes one rectangle/line command, walks it one pixel
// per cycle towards the offset stage and pulses done when finished.
module pattern_line_seq
  import pattern_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_x0,
  input  logic [CW-1:0] cmd_y0,
  input  logic [CW-1:0] cmd_len,
  input  logic [CW-1:0] cmd_rows,
  input  logic [1:0]    cmd_mode,
  input  logic          stall,
  output logic          add_enb,
  output logic [1:0]    add_mode,
  output logic [CW-1:0] add_base,
  output logic [CW-1:0] add_y,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  state_t        w_nextState;

  logic [CW-1:0] r_x0;
  logic [CW-1:0] r_len;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_xCur;
  logic [CW-1:0] r_yCur;
  logic [CW-1:0] r_pxLeft;
  logic [CW-1:0] r_rowsLeft;

  logic [3:0]    w_delta;
  logic [CW-1:0] w_deltaExt;
  logic          w_accept;
  logic          w_advance;
  logic          w_emptyCmd;
  logic          w_morePx;
  logic          w_moreRows;

  pattern_step_dec u_stepDec (
    .i_mode  (r_mode),
    .o_delta (w_delta)
  );

  assign w_deltaExt = CW'(w_delta);
  assign w_emptyCmd = (cmd_len == '0) || (cmd_rows == '0);
  assign w_morePx   = (r_pxLeft > CW'(1));
  assign w_moreRows = (r_rowsLeft > CW'(1));

  // State register; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the accept/advance strobes that drive the datapath
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = cmd_valid;
        if (cmd_valid) begin
          w_nextState = w_emptyCmd ? DONE : RUN;
        end
      end
      RUN: begin
        w_advance = !stall;
        if (!stall && !w_morePx && !w_moreRows) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Command latch and X/Y/count walk; a stalled cycle leaves everything frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0       <= '0;
      r_len      <= '0;
      r_mode     <= '0;
      r_xCur     <= '0;
      r_yCur     <= '0;
      r_pxLeft   <= '0;
      r_rowsLeft <= '0;
    end else if (w_accept) begin
      r_x0       <= cmd_x0;
      r_len      <= cmd_len;
      r_mode     <= cmd_mode;
      r_xCur     <= cmd_x0;
      r_yCur     <= cmd_y0;
      r_pxLeft   <= cmd_len;
      r_rowsLeft <= cmd_rows;
    end else if (w_advance) begin
      if (w_morePx) begin
        r_xCur   <= r_xCur + w_deltaExt;
        r_pxLeft <= r_pxLeft - CW'(1);
      end else if (w_moreRows) begin
        r_xCur     <= r_x0;
        r_yCur     <= r_yCur + CW'(1);
        r_pxLeft   <= r_len;
        r_rowsLeft <= r_rowsLeft - CW'(1);
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign add_enb   = (r_state == RUN) && !stall;
  assign add_base  = r_xCur;
  assign add_y     = r_yCur;
  assign add_mode  = r_mode;

endmodule

// File: tb/tb_pattern_line_seq.sv
// Scoreboard bench for pattern_line_seq: stimulus pushes hand-computed
// pixel/done events with their expected cycle, a monitor pops and compares.
module tb_pattern_line_seq;

  localparam int CW = 12;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [CW-1:0] cmd_x0    = '0;
  logic [CW-1:0] cmd_y0    = '0;
  logic [CW-1:0] cmd_len   = '0;
  logic [CW-1:0] cmd_rows  = '0;
  logic [1:0]    cmd_mode  = '0;
  logic          stall     = 1'b0;
  logic          cmd_ready;
  logic          add_enb;
  logic [1:0]    add_mode;
  logic [CW-1:0] add_base;
  logic [CW-1:0] add_y;
  logic          busy;
  logic          done;

  pattern_line_seq #(.CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_len   (cmd_len),
    .cmd_rows  (cmd_rows),
    .cmd_mode  (cmd_mode),
    .stall     (stall),
    .add_enb   (add_enb),
    .add_mode  (add_mode),
    .add_base  (add_base),
    .add_y     (add_y),
    .busy      (busy),
    .done      (done)
  );

  // 60 ns master clock
  always #30 clk = ~clk;

  // Edge counter used to timestamp every observed event
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            isDone;
    logic [CW-1:0] base;
    logic [CW-1:0] y;
    logic [1:0]    mode;
    int            cyc;
  } exp_t;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic [63:0] packObs(input bit d, input bit e,
                                          input logic [1:0] m,
                                          input logic [CW-1:0] b,
                                          input logic [CW-1:0] y,
                                          input int c);
    return {4'b0, d, e, m, b, y, 32'(c)};
  endfunction

  task automatic expPix(input logic [CW-1:0] b, input logic [CW-1:0] y,
                        input logic [1:0] m, input int c);
    exp_t e;
    e.isDone = 1'b0;
    e.base   = b;
    e.y      = y;
    e.mode   = m;
    e.cyc    = c;
    expQ.push_back(e);
  endtask

  task automatic expDone(input int c);
    exp_t e;
    e.isDone = 1'b1;
    e.base   = '0;
    e.y      = '0;
    e.mode   = '0;
    e.cyc    = c;
    expQ.push_back(e);
  endtask

  // Monitor: every pixel request or done pulse must match the queue head
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (rst_n && (add_enb || done)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput",
                    packObs(done, add_enb, add_mode, add_base, add_y, cyc), 64'd0);
      end else begin
        e  = expQ.pop_front();
        nm = e.isDone ? "doneEvent" : "pixelReq";
        if (e.isDone) begin
          checkOutput(nm, packObs(done, add_enb, 2'b0, '0, '0, cyc),
                      packObs(1'b1, 1'b0, 2'b0, '0, '0, e.cyc));
        end else begin
          checkOutput(nm, packObs(done, add_enb, add_mode, add_base, add_y, cyc),
                      packObs(1'b0, 1'b1, e.mode, e.base, e.y, e.cyc));
        end
      end
    end
  end

  // Present a command, wait (bounded) for acceptance, return the accept edge
  task automatic applyStimulus(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                               input logic [CW-1:0] len, input logic [CW-1:0] rows,
                               input logic [1:0] mode, input bit hold,
                               output int tAcc);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_len   = len;
    cmd_rows  = rows;
    cmd_mode  = mode;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) checkOutput("cmdReadyTimeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    tAcc = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int guard = 0;
    while (expQ.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #(60 * 5000);
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int t, tA, tB;

    // Reset state
    @(negedge clk);
    checkOutput("rstCmdReady", 64'(cmd_ready), 64'd1);
    checkOutput("rstBusy",     64'(busy),      64'd0);
    checkOutput("rstDone",     64'(done),      64'd0);
    checkOutput("rstAddEnb",   64'(add_enb),   64'd0);
    checkOutput("rstAddOut",   64'({add_mode, add_base, add_y}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Line x0=10 y0=5 len=4 mode=4, cmd_valid kept high with a rectangle behind it
    applyStimulus(12'd10, 12'd5, 12'd4, 12'd1, 2'b10, 1'b1, tA);
    expPix(12'd10, 12'd5, 2'b10, tA);
    expPix(12'd14, 12'd5, 2'b10, tA + 1);
    expPix(12'd18, 12'd5, 2'b10, tA + 2);
    expPix(12'd22, 12'd5, 2'b10, tA + 3);
    expDone(tA + 4);

    // Rectangle x0=0 y0=7 len=2 rows=3 mode=1; only accepted once idle again
    applyStimulus(12'd0, 12'd7, 12'd2, 12'd3, 2'b01, 1'b0, tB);
    checkOutput("cmdSpacing", 64'(tB - tA), 64'd6);
    expPix(12'd0, 12'd7, 2'b01, tB);
    expPix(12'd1, 12'd7, 2'b01, tB + 1);
    expPix(12'd0, 12'd8, 2'b01, tB + 2);
    expPix(12'd1, 12'd8, 2'b01, tB + 3);
    expPix(12'd0, 12'd9, 2'b01, tB + 4);
    expPix(12'd1, 12'd9, 2'b01, tB + 5);
    expDone(tB + 6);
    drainQueue();

    // Wrap in X and Y
    applyStimulus(12'hFFC, 12'hFFF, 12'd2, 12'd2, 2'b11, 1'b0, t);
    expPix(12'hFFC, 12'hFFF, 2'b11, t);
    expPix(12'h004, 12'hFFF, 2'b11, t + 1);
    expPix(12'hFFC, 12'h000, 2'b11, t + 2);
    expPix(12'h004, 12'h000, 2'b11, t + 3);
    expDone(t + 4);
    drainQueue();

    // Three stall cycles after the first pixel of a 3-pixel line
    applyStimulus(12'd20, 12'd1, 12'd3, 12'd1, 2'b01, 1'b0, t);
    expPix(12'd20, 12'd1, 2'b01, t);
    expPix(12'd21, 12'd1, 2'b01, t + 4);
    expPix(12'd22, 12'd1, 2'b01, t + 5);
    expDone(t + 6);
    @(posedge clk);
    #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallEnb",  64'(add_enb),  64'd0);
      checkOutput("stallHold", 64'({add_base, add_y}), 64'({12'd21, 12'd1}));
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    drainQueue();

    // Empty commands with stall held high: stall must not matter outside RUN
    stall = 1'b1;
    applyStimulus(12'd3, 12'd4, 12'd0, 12'd9, 2'b01, 1'b0, t);
    expDone(t);
    applyStimulus(12'd3, 12'd4, 12'd5, 12'd0, 2'b10, 1'b0, t);
    expDone(t);
    drainQueue();
    stall = 1'b0;

    // Reset in the middle of a long line: no done for the aborted command
    applyStimulus(12'd100, 12'd3, 12'd8, 12'd1, 2'b01, 1'b0, t);
    expPix(12'd100, 12'd3, 2'b01, t);
    expPix(12'd101, 12'd3, 2'b01, t + 1);
    expPix(12'd102, 12'd3, 2'b01, t + 2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("abortReady",  64'(cmd_ready), 64'd1);
    checkOutput("abortBusy",   64'(busy),      64'd0);
    checkOutput("abortEnb",    64'({add_enb, done}), 64'd0);
    checkOutput("abortAddOut", 64'({add_mode, add_base, add_y}), 64'd0);
    checkOutput("abortQueue",  64'(expQ.size()), 64'd0);
    @(negedge clk);
    #5;
    rst_n = 1'b1;

    // Fresh command after reset, mode 0 repeats the same X
    applyStimulus(12'd7, 12'd2, 12'd2, 12'd1, 2'b00, 1'b0, t);
    expPix(12'd7, 12'd2, 2'b00, t);
    expPix(12'd7, 12'd2, 2'b00, t + 1);
    expDone(t + 2);
    drainQueue();
    repeat (12) @(negedge clk);
    checkOutput("finalIdle", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pattern_line_seq.md
# pattern_line_seq

Command-driven raster sequencer that sits directly upstream of the pattern offset (delta-add) stage. It accepts one rectangle/line command at a time: start X, row Y, pixels per row, row count and step mode. It then issues one pixel request per cycle (base X, Y, step mode, enable) to the offset stage, advancing X by the step and Y by one per row. It signals completion with a single-cycle `done` pulse.

## Interface
Parameters:
- `CW`, 12: coordinate width for X, Y and counts (the offset stage is fixed at 12).

Ports:
- `clk`  in  1  master clock (60 ns)
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept; equals (state==IDLE)
- `cmd_x0`  in  CW  first X of each row
- `cmd_y0`  in  CW  first row Y
- `cmd_len`  in  CW  pixels per row; 0 = empty command
- `cmd_rows`  in  CW  number of rows; 0 = empty command
- `cmd_mode`  in  2  X step: 00=0, 01=1, 10=4, 11=8
- `stall`  in  1  downstream hold; active-high
- `add_enb`  out  1  pixel request valid (drives offset-stage enable)
- `add_mode`  out  2  latched `cmd_mode`
- `add_base`  out  CW  current X
- `add_y`  out  CW  current Y
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. Encoding lives in the package.
- IDLE:
  - On `cmd_valid && cmd_ready` at a clock edge, latch x0, y0, mode and len.
  - Load `x_cur=x0`, `y_cur=y0`, `px_left=len`, `rows_left=rows`.
  - Go to RUN if len!=0 and rows!=0; otherwise go to DONE.
- RUN:
  - `add_enb = !stall`. This is combinational from state and `stall`.
  - `add_base=x_cur`, `add_y=y_cur`, `add_mode=mode_q`. All come from registers.
  - On each edge with `add_enb=1`:
    - If px_left>1: `x_cur += delta(mode)` and `px_left--`.
    - Else, if rows_left>1: `x_cur=x0_q`, `y_cur++`, `px_left=len_q`, `rows_left--`.
    - Else: go to DONE.
  - Stall freezes all registers; `add_base` and `add_y` hold their values.
- DONE: `done=1` for exactly one cycle, then go to IDLE unconditionally.
- Arithmetic: CW-bit unsigned with modulo wrap on X and Y. Examples: 0xFFC+8 → 0x004; Y 0xFFF+1 → 0x000. No saturation and no error flag.
- Mode 00 repeats the same X `len` times.
- `cmd_valid` while busy is ignored. No queueing and no abort input.
- Reset values: state IDLE; all X/Y/count/mode registers 0; `add_enb=0`, `add_base=0`, `add_y=0`, `add_mode=0`, `done=0`, `busy=0`, `cmd_ready=1`.
- Reset mid-operation aborts immediately to reset values. No `done` is produced for the aborted command.

## Timing
- Command accepted at edge T: the first pixel request is visible in cycle T+1, provided stall is low.
- No stalls: requests are visible in cycles T+1 … T+len·rows with no gap between rows.
  - `done` is high in cycle T+len·rows+1.
  - `cmd_ready` returns the following cycle.
- Empty command (len=0 or rows=0): `done` is high in cycle T+1; `add_enb` never asserts.
- Each stall cycle in RUN adds exactly one cycle of latency. Stall in IDLE or DONE has no effect.
- Throughput is one pixel per cycle. Minimum command-to-command spacing is len·rows+2 cycles.
- The offset stage registers `add_base+delta` one edge after each `add_enb` cycle. This block does not observe that result.

## Structure
- Shared package `pattern_pkg`:
  - state enum (IDLE/RUN/DONE);
  - step-mode constants ZERO=2'b00, ONE=2'b01, FOUR=2'b10, EIGHT=2'b11;
  - CW default.
- One sub-module: `pattern_step_dec`, combinational 2-bit mode → 4-bit delta (0/1/4/8). The offset stage reuses it so both sides share one decode.
- Counters and FSM stay in the top module.

## Test plan
- Line: x0=10, y0=5, len=4, rows=1, mode=10 → add_base 10,14,18,22 with add_y=5 in T+1..T+4; done at T+5; cmd_ready=1 at T+6.
- Rectangle: x0=0, y0=7, len=2, rows=3, mode=01 → (0,7),(1,7),(0,8),(1,8),(0,9),(1,9) back-to-back; done at T+7.
- Wrap: x0=0xFFC, len=2, mode=11, y0=0xFFF, rows=2 → X 0xFFC,0x004; Y wraps 0xFFF→0x000; done at T+5.
- Stall and empty command: stall high for 3 cycles mid-line in len=3, rows=1 → add_base held, add_enb=0, done delayed 3 cycles. Then len=0, rows=9 → done at T+1, no add_enb.
- Busy and reset: cmd_valid held during RUN → ignored until cmd_ready. Assert rst_n low mid-RUN → all outputs 0 and cmd_ready=1 immediately, no done; a new command after release runs normally.
